// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the controller state encoding and the address-liveness helper.
package regfile_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // An address is live when it names a real, writable register (not r0, not past the end).
    function automatic logic addr_live(input int unsigned addr, input int unsigned depth);
        return (addr != 0) && (addr < depth);
    endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port output mux: stored word, overridden by same-cycle writes (highest port wins).
// Latency: combinational.
// Backpressure: none; output forced to zero when out_en is low.
module rf_bypass_mux
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NWR    = 2
) (
    input  logic                     out_en,
    input  logic                     byp_en,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        rd_word,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    waddr,
    input  logic [NWR*DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]        rdata
);

    always_comb begin
        rdata = '0;
        if (out_en && addr_live(32'(raddr), DEPTH)) begin
            rdata = rd_word;
            if (byp_en) begin
                // Ascending scan so the highest-numbered matching port is applied last.
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr)) begin
                        rdata = wdata[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero and a sequential self-clear.
// Latency: reads combinational with write-first bypass; writes land on the next edge.
// Backpressure: ready low during clear; writes then are dropped and reads return zero.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    waddr,
    input  logic [NWR*DATA_W-1:0]    wdata,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    output logic                     ready
);

    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_ENTRY = ADDR_W'(1);

    rf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_ENTRY) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = FIRST_ENTRY;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = FIRST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= FIRST_ENTRY;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready     <= (state_d == READY);
        end
    end

    // Storage has no reset; the clear walk is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else if (!clear_req) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && addr_live(32'(waddr[k*ADDR_W +: ADDR_W]), DEPTH)) begin
                        mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    logic out_en;
    assign out_en = (state_q == READY) && !rst;

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[r*ADDR_W +: ADDR_W];

        rf_bypass_mux #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_mux (
            .out_en  (out_en),
            .byp_en  (!clear_req),
            .raddr   (ra),
            .rd_word (mem[ra]),
            .we      (we),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[r*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against a flat array model of the register file.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic [1:0]    we;
    logic [9:0]    waddr;
    logic [63:0]   wdata;
    logic [9:0]    raddr;
    logic [63:0]   rdata;
    logic          ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [D];
    bit          rdy_m;
    int          clr_left;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DW),
        .DEPTH  (D),
        .ADDR_W (AW),
        .NRD    (2),
        .NWR    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .ready     (ready)
    );

    // Expected read data for port p given the current inputs and model contents.
    function automatic logic [31:0] exp_rd(int p);
        logic [4:0]  a;
        logic [31:0] v;
        a = raddr[p*AW +: AW];
        if (rst || !rdy_m || a == 5'd0) return '0;
        v = mem_m[a];
        if (!clear_req) begin
            for (int k = 0; k < 2; k++) begin
                if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] fill_val(int a);
        return 32'(a) * 32'h0101_0101 + 32'h0000_1000;
    endfunction

    // Advance one clock edge and apply the architectural effect of the inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            rdy_m    = 1'b0;
            clr_left = D - 1;
        end else if (!rdy_m) begin
            clr_left--;
            if (clr_left == 0) begin
                rdy_m = 1'b1;
                foreach (mem_m[i]) mem_m[i] = '0;
            end
        end else if (clear_req) begin
            rdy_m    = 1'b0;
            clr_left = D - 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we[k] && waddr[k*AW +: AW] != 5'd0)
                    mem_m[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; clear_req = 1'b0; we = 2'b11;
        waddr = {5'd9, 5'd4}; wdata = {32'hAAAA_0001, 32'hBBBB_0002}; raddr = {5'd9, 5'd4};
        tick(); tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        rst = 1'b0;
        n = 0;
        do begin
            waddr = 10'($urandom); wdata = {$urandom, $urandom}; raddr = 10'($urandom);
            #1;
            checks++;
            if (rdata !== 64'h0) begin errors++; $display("FAIL reset_clear_rdata: got %h expected 0", rdata); end
            tick();
            n++;
        end while (ready !== 1'b1 && n < 100);
        we = 2'b00;
        checks++;
        if (n != 31) begin errors++; $display("FAIL reset_clear_len: got %0d edges expected 31", n); end
        for (int a = 0; a < D; a++) begin
            raddr = {2{5'(a)}};
            #1;
            checks++;
            if (rdata !== 64'h0) begin errors++; $display("FAIL reset_zero r%0d: got %h expected 0", a, rdata); end
        end
    endtask

    task automatic test_bypass();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF}; raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same: got %h expected deadbeef", rdata[31:0]); end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_after: got %h expected deadbeef", rdata[31:0]); end
    endtask

    task automatic test_conflict();
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rdata !== {32'h22, 32'h22}) begin errors++; $display("FAIL conflict_same: got %h expected both 22", rdata); end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rdata !== {32'h22, 32'h22}) begin errors++; $display("FAIL conflict_after: got %h expected both 22", rdata); end
    endtask

    task automatic test_zero_reg();
        we = 2'b11; waddr = {5'd0, 5'd0}; wdata = {64{1'b1}}; raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rdata !== 64'h0) begin errors++; $display("FAIL zero_same: got %h expected 0", rdata); end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rdata !== 64'h0) begin errors++; $display("FAIL zero_after: got %h expected 0", rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear_req = ($urandom_range(0, 59) == 0);
            we    = 2'($urandom);
            waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            raddr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr[4:0];
            if ($urandom_range(0, 3) == 0) raddr[9:5] = waddr[9:5];
            if ($urandom_range(0, 5) == 0) waddr[9:5] = waddr[4:0];
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rdata[p*DW +: DW] !== exp_rd(p)) begin
                    errors++;
                    $display("FAIL random_rdata%0d cyc %0d: got %h expected %h", p, i, rdata[p*DW +: DW], exp_rd(p));
                end
            end
            checks++;
            if (ready !== rdy_m) begin errors++; $display("FAIL random_ready cyc %0d: got %b expected %b", i, ready, rdy_m); end
            tick();
        end
        clear_req = 1'b0; we = 2'b00;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
    endtask

    task automatic test_clear();
        int n;
        for (int a = 1; a < D; a++) begin
            we = 2'b01; waddr = {5'd0, 5'(a)}; wdata = {32'h0, fill_val(a)};
            tick();
        end
        clear_req = 1'b1; we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h55}; raddr = {5'd9, 5'd3};
        #1;
        checks++;
        if (rdata !== {fill_val(9), fill_val(3)}) begin
            errors++;
            $display("FAIL clear_nobypass: got %h expected %h", rdata, {fill_val(9), fill_val(3)});
        end
        tick();
        clear_req = 1'b0; we = 2'b00;
        n = 0;
        do begin
            clear_req = (n == 5);
            we = 2'b11; waddr = 10'($urandom); wdata = {$urandom, $urandom};
            #1;
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_low edge %0d: got %b expected 0", n, ready); end
            tick();
            n++;
        end while (ready !== 1'b1 && n < 100);
        clear_req = 1'b0; we = 2'b00;
        checks++;
        if (n != 31) begin errors++; $display("FAIL clear_len: got %0d edges expected 31", n); end
        for (int a = 0; a < D; a++) begin
            raddr = {2{5'(a)}};
            #1;
            checks++;
            if (rdata !== 64'h0) begin errors++; $display("FAIL clear_zero r%0d: got %h expected 0", a, rdata); end
        end
    endtask

    task automatic test_rst_midclear();
        int n;
        for (int a = 1; a < D; a++) begin
            we = 2'b01; waddr = {5'd0, 5'(a)}; wdata = {32'h0, ~fill_val(a)};
            tick();
        end
        we = 2'b00;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        // Nine more edges leave the clear pointer at entry 10.
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midclear_ready: got %b expected 0", ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (ready !== 1'b1 && n < 100);
        checks++;
        if (n != 31) begin errors++; $display("FAIL midclear_len: got %0d edges expected 31", n); end
        for (int a = 0; a < D; a++) begin
            raddr = {2{5'(a)}};
            #1;
            checks++;
            if (rdata !== 64'h0) begin errors++; $display("FAIL midclear_zero r%0d: got %h expected 0", a, rdata); end
        end
    endtask

    initial begin
        rst = 1'b1; clear_req = 1'b0; we = 2'b00;
        waddr = '0; wdata = '0; raddr = '0;
        rdy_m = 1'b0; clr_left = D - 1;
        foreach (mem_m[i]) mem_m[i] = '0;
        test_reset();
        test_bypass();
        test_conflict();
        test_zero_reg();
        test_random();
        test_clear();
        test_rst_midclear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
